multicore_io_arbiter: RTL and testbench
=======================================

# multicore_io_arbiter

Parametrised switch/display arbiter between the board I/O pins and N lhnRISC621 cores in the multicore top level. During the input phase it broadcasts the user switches to every core. Once all cores report Done, it hands the switches and the LED display to one core at a time, round-robin. Each core keeps ownership for a fixed number of pushbutton presses before ownership moves to the next core.

## Interface
- NUM_CORES, 4, number of cores served (2..16).
- SW_W, 5, switch width; bit 0 is the step pushbutton.
- DISP_W, 8, display width per core.
- OPS_PER_CORE, 8, button presses per core before ownership advances (1..255).
- WRAP, 1, 1 = after the last core return to core 0; 0 = stop in END.
- Clock_pin  in  1  system clock; all logic on the rising edge.
- Reset_pin  in  1  asynchronous, active-high reset.
- SW_pin  in  SW_W  raw board switches and pushbutton.
- Done  in  NUM_CORES  per-core done flags, synchronous to Clock_pin.
- Display_core  in  NUM_CORES*DISP_W  core i display on bits [i*DISP_W +: DISP_W].
- SW_core  out  NUM_CORES*SW_W  switch value for core i on bits [i*SW_W +: SW_W]; registered.
- Display_pin  out  DISP_W  registered LED output.
- Active_core  out  clog2(NUM_CORES)  index of the core owning the I/O.
- Phase  out  2  state: LOAD=0, WAIT=1, SHOW=2, END=3.
- Ops_left  out  8  presses remaining for the active core.

## Operation
- sw_s is the switch sample: SW_pin registered (see Configuration). btn_prev holds sw_s[0] from the previous cycle and updates every cycle in every state. A press is btn_prev=1 and sw_s[0]=0 (release edge).
- LOAD:
  - Every SW_core slice is set to sw_s; Display_pin shows core 0.
  - Done all ones -> SHOW. Otherwise any Done bit set -> WAIT.
  - Presses are ignored.
- WAIT:
  - SW_core slices are frozen; Display_pin still shows core 0.
  - Done all ones -> SHOW. Done all zeros -> LOAD.
- Entry to SHOW loads Active_core=0 and Ops_left=OPS_PER_CORE.
- SHOW:
  - SW_core[Active_core] follows sw_s; the other slices hold their last value.
  - Display_pin shows Display_core[Active_core].
  - A press with Ops_left>1 decrements Ops_left.
  - A press with Ops_left==1:
    - Ops_left reloads to OPS_PER_CORE.
    - If Active_core<NUM_CORES-1, Active_core increments.
    - Otherwise, with WRAP=1, Active_core goes to 0. With WRAP=0, the state goes to END.
- END:
  - All SW_core slices are frozen; Display_pin shows core NUM_CORES-1.
  - Ops_left holds OPS_PER_CORE.
- In SHOW and END, Done all zeros -> LOAD and all counters reset. Partial Done drops are ignored.
- Widths and arithmetic:
  - Ops_left is 8 bits and never underflows.
  - Active_core wraps by explicit compare with NUM_CORES-1, never by natural overflow, so non-power-of-2 counts are legal.

## Timing
- Reset values: SW_core=0, Display_pin=0, Active_core=0, Phase=LOAD, Ops_left=OPS_PER_CORE, btn_prev=0, sw_s=0. All are applied immediately, without waiting for a clock edge.
- Reset asserted mid-SHOW aborts the rotation. After release the block starts in LOAD.
- Switch latency: a change on SW_pin reaches SW_core 2 cycles later with synchronisation compiled out, 3 cycles with it.
- State change: the Phase transition occurs 1 cycle after the Done condition holds.
- Press latency: Ops_left and Active_core update 1 cycle after the release edge reaches sw_s. Display_pin switches to the new core in that same cycle.
- Simultaneous events in one cycle:
  - A press in the cycle of LOAD/WAIT->SHOW is not counted; btn_prev is already current.
  - Done falling to zero in the same cycle as a press: the state goes to LOAD and the press is discarded.

## Configuration
- MCIO_SW_SYNC_EN defined: SW_pin passes through a two-flop synchroniser before sw_s. Switch latency becomes 3 cycles.
- MCIO_SW_SYNC_EN undefined: single register stage; latency 2 cycles.
- All tests are run in both builds with latencies adjusted.

## Test plan
- Reset: hold Reset_pin=1 with SW_pin=5'h1F -> all outputs at reset values, Phase=0. Release, wait 3 cycles -> every SW_core slice = 5'h1F, Display_pin = Display_core[0].
- Partial done: NUM_CORES=4, Done=4'b0011 -> Phase=1, SW_core frozen while SW_pin changes. Done=4'b1111 -> Phase=2, Active_core=0.
- Rotation: OPS_PER_CORE=2, all Done, Display_core[i]=8'h10+i. Issue 2 presses -> Active_core=1, Display_pin=8'h11. 6 more presses -> Active_core=0 (WRAP=1), Display_pin=8'h10.
- No-wrap: WRAP=0, OPS_PER_CORE=1, 4 presses -> Phase=3, Display_pin=8'h13. Further presses do not change any output.
- Ownership: in SHOW with Active_core=2, change SW_pin to 5'h0A (bit 0 stays 0, so no press) -> only SW_core slice 2 updates. Slices 0, 1 and 3 hold their values.
- Abort: reset mid-SHOW at Ops_left=1 -> immediate reset values. Separately, Done->0 in SHOW -> Phase=0 next cycle, Ops_left=OPS_PER_CORE.

Source files
------------

// File: rtl/multicore_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : multicore_io_arbiter
// Purpose  : Broadcasts board switches to N cores, then rotates switch/LED
//            ownership round-robin once every core reports Done.
// Option   : MCIO_SW_SYNC_EN adds a metastability flop ahead of the switch sample.
// Revision : 1.0 - initial release
// ============================================================================
module multicore_io_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int SW_W         = 5,
  parameter int DISP_W       = 8,
  parameter int OPS_PER_CORE = 8,
  parameter int WRAP         = 1
) (
  input  logic                          Clock_pin,
  input  logic                          Reset_pin,
  input  logic [SW_W-1:0]               SW_pin,
  input  logic [NUM_CORES-1:0]          Done,
  input  logic [NUM_CORES*DISP_W-1:0]   Display_core,
  output logic [NUM_CORES*SW_W-1:0]     SW_core,
  output logic [DISP_W-1:0]             Display_pin,
  output logic [$clog2(NUM_CORES)-1:0]  Active_core,
  output logic [1:0]                    Phase,
  output logic [7:0]                    Ops_left
);

  localparam int AW = $clog2(NUM_CORES);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  localparam logic [AW-1:0] c_LAST_CORE = AW'(NUM_CORES - 1);
  localparam logic [7:0]    c_OPS       = 8'(OPS_PER_CORE);
  localparam logic          c_WRAP      = (WRAP != 0);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [SW_W-1:0]   r_sw_s;
  logic              r_btn_prev;
  logic [AW-1:0]     r_active;
  logic [AW-1:0]     w_active_nxt;
  logic [7:0]        r_ops;
  logic [7:0]        w_ops_nxt;
  logic [DISP_W-1:0] r_disp;
  logic [AW-1:0]     w_disp_idx;
  logic              w_load_all;
  logic              w_load_own;
  logic              w_press;
  logic              w_all_done;
  logic              w_none_done;
  logic              w_last_op;
  logic              w_last_core;

  // ---------------------------------------------------------------------------
  // Switch sample
  // ---------------------------------------------------------------------------
`ifdef MCIO_SW_SYNC_EN
  logic [SW_W-1:0] r_sw_meta;

  always_ff @(posedge Clock_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      r_sw_meta <= '0;
      r_sw_s    <= '0;
    end else begin
      r_sw_meta <= SW_pin;
      r_sw_s    <= r_sw_meta;
    end
  end
`else
  always_ff @(posedge Clock_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      r_sw_s <= '0;
    end else begin
      r_sw_s <= SW_pin;
    end
  end
`endif

  always_ff @(posedge Clock_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_prev <= r_sw_s[0];
    end
  end

  // A press is the release of the step button.
  assign w_press     = r_btn_prev & ~r_sw_s[0];
  assign w_all_done  = &Done;
  assign w_none_done = ~|Done;
  assign w_last_op   = (r_ops == 8'd1);
  assign w_last_core = (r_active == c_LAST_CORE);

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_all_done) begin
          w_state_nxt = S_SHOW;
        end else if (!w_none_done) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_all_done) begin
          w_state_nxt = S_SHOW;
        end else if (w_none_done) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_SHOW: begin
        if (w_none_done) begin
          w_state_nxt = S_LOAD;
        end else if (w_press && w_last_op && w_last_core && !c_WRAP) begin
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        if (w_none_done) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Display selection follows the next owner so the LEDs move with Active_core.
  always_comb begin
    w_load_all = (r_state == S_LOAD);
    w_load_own = (r_state == S_SHOW);
    w_disp_idx = '0;
    case (w_state_nxt)
      S_SHOW:  w_disp_idx = w_active_nxt;
      S_END:   w_disp_idx = c_LAST_CORE;
      default: w_disp_idx = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Ownership counters
  // ---------------------------------------------------------------------------
  always_comb begin
    w_active_nxt = r_active;
    w_ops_nxt    = r_ops;
    if ((r_state == S_SHOW) && (w_state_nxt == S_SHOW)) begin
      if (w_press) begin
        if (!w_last_op) begin
          w_ops_nxt = r_ops - 8'd1;
        end else begin
          w_ops_nxt    = c_OPS;
          w_active_nxt = w_last_core ? '0 : r_active + 1'b1;
        end
      end
    end else if (w_state_nxt == S_END) begin
      // The last owner stays selected while the rotation is parked.
      w_ops_nxt = c_OPS;
    end else begin
      w_active_nxt = '0;
      w_ops_nxt    = c_OPS;
    end
  end

  always_ff @(posedge Clock_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      r_active <= '0;
      r_ops    <= c_OPS;
      r_disp   <= '0;
    end else begin
      r_active <= w_active_nxt;
      r_ops    <= w_ops_nxt;
      r_disp   <= Display_core[w_disp_idx*DISP_W +: DISP_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Per-core switch registers
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_slice
      logic [SW_W-1:0] r_slice;

      always_ff @(posedge Clock_pin or posedge Reset_pin) begin
        if (Reset_pin) begin
          r_slice <= '0;
        end else if (w_load_all || (w_load_own && (r_active == AW'(gi)))) begin
          r_slice <= r_sw_s;
        end
      end

      assign SW_core[gi*SW_W +: SW_W] = r_slice;
    end
  endgenerate

  assign Display_pin = r_disp;
  assign Active_core = r_active;
  assign Phase       = r_state;
  assign Ops_left    = r_ops;

endmodule
`default_nettype wire

// File: tb/tb_multicore_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicore_io_arbiter
// Purpose  : Directed bench; instance A wraps with 2 presses per core,
//            instance B parks in END with 1 press per core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicore_io_arbiter;

`ifdef MCIO_SW_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        Clock_pin = 1'b0;
  logic        Reset_pin = 1'b0;
  logic [4:0]  SW_pin;
  logic [3:0]  Done;
  logic [31:0] Display_core;

  logic [19:0] sw_core_a, sw_core_b;
  logic [7:0]  disp_a, disp_b;
  logic [1:0]  active_a, active_b;
  logic [1:0]  phase_a, phase_b;
  logic [7:0]  ops_a, ops_b;

  int n_vec = 0;
  int n_err = 0;

  multicore_io_arbiter #(
    .NUM_CORES(4), .SW_W(5), .DISP_W(8), .OPS_PER_CORE(2), .WRAP(1)
  ) u_dut_a (
    .Clock_pin(Clock_pin), .Reset_pin(Reset_pin), .SW_pin(SW_pin), .Done(Done),
    .Display_core(Display_core), .SW_core(sw_core_a), .Display_pin(disp_a),
    .Active_core(active_a), .Phase(phase_a), .Ops_left(ops_a)
  );

  multicore_io_arbiter #(
    .NUM_CORES(4), .SW_W(5), .DISP_W(8), .OPS_PER_CORE(1), .WRAP(0)
  ) u_dut_b (
    .Clock_pin(Clock_pin), .Reset_pin(Reset_pin), .SW_pin(SW_pin), .Done(Done),
    .Display_core(Display_core), .SW_core(sw_core_b), .Display_pin(disp_b),
    .Active_core(active_b), .Phase(phase_b), .Ops_left(ops_b)
  );

  always #5 Clock_pin = ~Clock_pin;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock_pin);
      #1;
    end
  endtask

  task automatic press(input logic [4:0] base);
    SW_pin = base | 5'h01;
    tick(2);
    SW_pin = base;
    tick(LAT + 1);
  endtask

  task automatic test_reset;
    Reset_pin = 1'b1;
    SW_pin    = 5'h1F;
    tick(2);
    n_vec++; if (sw_core_a !== 20'h0) begin n_err++; $display("FAIL reset_sw_core: got %h want %h", sw_core_a, 20'h0); end
    n_vec++; if (disp_a !== 8'h00) begin n_err++; $display("FAIL reset_disp: got %h want %h", disp_a, 8'h00); end
    n_vec++; if (active_a !== 2'd0) begin n_err++; $display("FAIL reset_active: got %0d want 0", active_a); end
    n_vec++; if (phase_a !== 2'd0) begin n_err++; $display("FAIL reset_phase: got %0d want 0", phase_a); end
    n_vec++; if (ops_a !== 8'd2) begin n_err++; $display("FAIL reset_ops_a: got %0d want 2", ops_a); end
    n_vec++; if (ops_b !== 8'd1) begin n_err++; $display("FAIL reset_ops_b: got %0d want 1", ops_b); end
    Reset_pin = 1'b0;
    tick(3);
    n_vec++; if (sw_core_a !== {4{5'h1F}}) begin n_err++; $display("FAIL load_broadcast: got %h want %h", sw_core_a, {4{5'h1F}}); end
    n_vec++; if (disp_a !== 8'h10) begin n_err++; $display("FAIL load_disp: got %h want 10", disp_a); end
  endtask

  task automatic test_partial_done;
    Done = 4'b0011;
    tick(1);
    n_vec++; if (phase_a !== 2'd1) begin n_err++; $display("FAIL wait_phase: got %0d want 1", phase_a); end
    SW_pin = 5'h04;
    tick(LAT + 1);
    n_vec++; if (sw_core_a !== {4{5'h1F}}) begin n_err++; $display("FAIL wait_frozen: got %h want %h", sw_core_a, {4{5'h1F}}); end
    n_vec++; if (disp_a !== 8'h10) begin n_err++; $display("FAIL wait_disp: got %h want 10", disp_a); end
    Done = 4'b1111;
    tick(1);
    n_vec++; if (phase_a !== 2'd2) begin n_err++; $display("FAIL show_phase: got %0d want 2", phase_a); end
    n_vec++; if (active_a !== 2'd0) begin n_err++; $display("FAIL show_active: got %0d want 0", active_a); end
    n_vec++; if (ops_a !== 8'd2) begin n_err++; $display("FAIL show_ops: got %0d want 2", ops_a); end
    tick(1);
    n_vec++; if (sw_core_a !== {5'h1F, 5'h1F, 5'h1F, 5'h04}) begin n_err++; $display("FAIL show_slice0: got %h want %h", sw_core_a, {5'h1F, 5'h1F, 5'h1F, 5'h04}); end
  endtask

  task automatic test_rotation_first;
    press(5'h04);
    n_vec++; if (ops_a !== 8'd1) begin n_err++; $display("FAIL rot_dec: got %0d want 1", ops_a); end
    n_vec++; if (active_a !== 2'd0) begin n_err++; $display("FAIL rot_hold: got %0d want 0", active_a); end
    press(5'h04);
    n_vec++; if (active_a !== 2'd1) begin n_err++; $display("FAIL rot_active1: got %0d want 1", active_a); end
    n_vec++; if (disp_a !== 8'h11) begin n_err++; $display("FAIL rot_disp1: got %h want 11", disp_a); end
    n_vec++; if (ops_a !== 8'd2) begin n_err++; $display("FAIL rot_reload: got %0d want 2", ops_a); end
    n_vec++; if (active_a !== 2'd1 || active_b !== 2'd2) begin n_err++; $display("FAIL rot_b_active: got %0d want 2", active_b); end
    n_vec++; if (disp_b !== 8'h12) begin n_err++; $display("FAIL rot_b_disp: got %h want 12", disp_b); end
  endtask

  task automatic test_ownership;
    SW_pin = 5'h0A;
    tick(LAT + 1);
    n_vec++; if (sw_core_b !== {5'h1F, 5'h0A, 5'h04, 5'h04}) begin n_err++; $display("FAIL own_b: got %h want %h", sw_core_b, {5'h1F, 5'h0A, 5'h04, 5'h04}); end
    n_vec++; if (sw_core_a !== {5'h1F, 5'h1F, 5'h0A, 5'h04}) begin n_err++; $display("FAIL own_a: got %h want %h", sw_core_a, {5'h1F, 5'h1F, 5'h0A, 5'h04}); end
  endtask

  task automatic test_wrap_and_end;
    press(5'h0A);
    press(5'h0A);
    n_vec++; if (phase_b !== 2'd3) begin n_err++; $display("FAIL end_phase: got %0d want 3", phase_b); end
    n_vec++; if (disp_b !== 8'h13) begin n_err++; $display("FAIL end_disp: got %h want 13", disp_b); end
    n_vec++; if (active_b !== 2'd3) begin n_err++; $display("FAIL end_active: got %0d want 3", active_b); end
    n_vec++; if (sw_core_b !== {5'h0A, 5'h0A, 5'h04, 5'h04}) begin n_err++; $display("FAIL end_sw: got %h want %h", sw_core_b, {5'h0A, 5'h0A, 5'h04, 5'h04}); end
    n_vec++; if (active_a !== 2'd2) begin n_err++; $display("FAIL rot_active2: got %0d want 2", active_a); end
    for (int i = 0; i < 4; i++) press(5'h0A);
    n_vec++; if (active_a !== 2'd0) begin n_err++; $display("FAIL wrap_active: got %0d want 0", active_a); end
    n_vec++; if (disp_a !== 8'h10) begin n_err++; $display("FAIL wrap_disp: got %h want 10", disp_a); end
    n_vec++; if (phase_a !== 2'd2) begin n_err++; $display("FAIL wrap_phase: got %0d want 2", phase_a); end
    n_vec++; if (sw_core_a !== {4{5'h0A}}) begin n_err++; $display("FAIL wrap_sw: got %h want %h", sw_core_a, {4{5'h0A}}); end
    n_vec++; if (phase_b !== 2'd3 || disp_b !== 8'h13 || ops_b !== 8'd1) begin n_err++; $display("FAIL end_hold: got phase %0d disp %h ops %0d want 3 13 1", phase_b, disp_b, ops_b); end
    n_vec++; if (sw_core_b !== {5'h0A, 5'h0A, 5'h04, 5'h04}) begin n_err++; $display("FAIL end_sw_hold: got %h want %h", sw_core_b, {5'h0A, 5'h0A, 5'h04, 5'h04}); end
  endtask

  task automatic test_reset_abort;
    press(5'h0A);
    n_vec++; if (ops_a !== 8'd1) begin n_err++; $display("FAIL abort_pre_ops: got %0d want 1", ops_a); end
    #2 Reset_pin = 1'b1;
    #1;
    n_vec++; if (sw_core_a !== 20'h0 || disp_a !== 8'h00) begin n_err++; $display("FAIL async_reset_io: got sw %h disp %h want 0 0", sw_core_a, disp_a); end
    n_vec++; if (phase_a !== 2'd0 || ops_a !== 8'd2 || active_a !== 2'd0) begin n_err++; $display("FAIL async_reset_ctl: got phase %0d ops %0d active %0d want 0 2 0", phase_a, ops_a, active_a); end
    n_vec++; if (phase_b !== 2'd0 || active_b !== 2'd0) begin n_err++; $display("FAIL async_reset_b: got phase %0d active %0d want 0 0", phase_b, active_b); end
    Reset_pin = 1'b0;
    tick(1);
    n_vec++; if (phase_a !== 2'd2 || ops_a !== 8'd2 || disp_a !== 8'h10) begin n_err++; $display("FAIL restart: got phase %0d ops %0d disp %h want 2 2 10", phase_a, ops_a, disp_a); end
  endtask

  task automatic test_done_abort;
    press(5'h0A);
    n_vec++; if (ops_a !== 8'd1 || active_b !== 2'd1) begin n_err++; $display("FAIL abort_setup: got ops_a %0d active_b %0d want 1 1", ops_a, active_b); end
    Done = 4'b0101;
    tick(2);
    n_vec++; if (phase_a !== 2'd2 || ops_a !== 8'd1) begin n_err++; $display("FAIL partial_drop: got phase %0d ops %0d want 2 1", phase_a, ops_a); end
    Done = 4'b0000;
    tick(1);
    n_vec++; if (phase_a !== 2'd0 || ops_a !== 8'd2 || active_a !== 2'd0) begin n_err++; $display("FAIL done_abort: got phase %0d ops %0d active %0d want 0 2 0", phase_a, ops_a, active_a); end
    n_vec++; if (disp_a !== 8'h10) begin n_err++; $display("FAIL done_abort_disp: got %h want 10", disp_a); end
    n_vec++; if (phase_b !== 2'd0 || active_b !== 2'd0 || ops_b !== 8'd1) begin n_err++; $display("FAIL done_abort_b: got phase %0d active %0d ops %0d want 0 0 1", phase_b, active_b, ops_b); end
  endtask

  initial begin
    SW_pin       = 5'h1F;
    Done         = 4'b0000;
    Display_core = {8'h13, 8'h12, 8'h11, 8'h10};
    #1;
    test_reset;
    test_partial_done;
    test_rotation_first;
    test_ownership;
    test_wrap_and_end;
    test_reset_abort;
    test_done_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
